led_matrix_scanner: RTL and testbench



---
 rtl/led_pkg.sv | 16 +
 rtl/frame_double_buffer.sv | 73 +++++++
 rtl/led_matrix_scanner.sv | 111 +++++++++++
 tb/tb_led_matrix_scanner.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants and types for the LED matrix display path.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package led_pkg;

   localparam int ROWS   = 16;
   localparam int COLS   = 16;
   localparam int ROW_AW = $clog2(ROWS);

   // Scan FSM state encoding
   localparam logic [0:0] S_BLANK = 1'b0;
   localparam logic [0:0] S_DRIVE = 1'b1;

   typedef logic [COLS-1:0] row_t;

endpackage

// File: rtl/frame_double_buffer.sv
// Shadow/active frame storage: shadow takes new frames, active feeds the scanner.
// Latency: capture on the accepting edge; shadow->active copy on the swap edge.
// Backpressure: wr_ready low while shadow holds an unswapped frame.
// Ports: clock/reset_n; wr_red/wr_green/wr_valid/wr_ready frame input;
//        swap strobe from the scanner; rd_addr/rd_red/rd_green row read port.
module frame_double_buffer
   import led_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [ROWS*COLS-1:0]   wr_red,
   input  logic [ROWS*COLS-1:0]   wr_green,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic                   swap,
   input  logic [ROW_AW-1:0]      rd_addr,
   output row_t                   rd_red,
   output row_t                   rd_green
);

   row_t shadow_red_q   [ROWS];
   row_t shadow_red_d   [ROWS];
   row_t shadow_green_q [ROWS];
   row_t shadow_green_d [ROWS];
   row_t active_red_q   [ROWS];
   row_t active_red_d   [ROWS];
   row_t active_green_q [ROWS];
   row_t active_green_d [ROWS];
   logic shadow_full_q;
   logic shadow_full_d;

   assign wr_ready = ~shadow_full_q;
   assign rd_red   = active_red_q[rd_addr];
   assign rd_green = active_green_q[rd_addr];

   // Swap and capture are mutually exclusive: swap needs a full shadow,
   // capture needs an empty one.
   always_comb begin
      shadow_red_d   = shadow_red_q;
      shadow_green_d = shadow_green_q;
      active_red_d   = active_red_q;
      active_green_d = active_green_q;
      shadow_full_d  = shadow_full_q;
      if (swap && shadow_full_q) begin
         active_red_d   = shadow_red_q;
         active_green_d = shadow_green_q;
         shadow_full_d  = 1'b0;
      end else if (wr_valid && !shadow_full_q) begin
         for (int r = 0; r < ROWS; r++) begin
            shadow_red_d[r]   = wr_red[r*COLS +: COLS];
            shadow_green_d[r] = wr_green[r*COLS +: COLS];
         end
         shadow_full_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shadow_red_q   <= '{default: '0};
         shadow_green_q <= '{default: '0};
         active_red_q   <= '{default: '0};
         active_green_q <= '{default: '0};
         shadow_full_q  <= 1'b0;
      end else begin
         shadow_red_q   <= shadow_red_d;
         shadow_green_q <= shadow_green_d;
         active_red_q   <= active_red_d;
         active_green_q <= active_green_d;
         shadow_full_q  <= shadow_full_d;
      end
   end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix driver with double-buffered frame input.
// Latency: new frame shown from row 0 of the scan after the next frame_done.
// Backpressure: frame_ready low while a frame waits in shadow; scan never stalls.
// Ports: clock/reset_n; frame_red/frame_green/frame_valid/frame_ready input;
//        frame_done scan-end pulse; row_addr/row_en/red_col/green_col to the matrix.
module led_matrix_scanner
   import led_pkg::*;
#(
   parameter int DWELL_CYCLES = 1024,
   parameter int BLANK_CYCLES = 64
)
(
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [ROWS*COLS-1:0]   frame_red,
   input  logic [ROWS*COLS-1:0]   frame_green,
   input  logic                   frame_valid,
   output logic                   frame_ready,
   output logic                   frame_done,
   output logic [ROW_AW-1:0]      row_addr,
   output logic                   row_en,
   output logic [COLS-1:0]        red_col,
   output logic [COLS-1:0]        green_col
);

   localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [ROW_AW-1:0] ROW_LAST   = ROW_AW'(ROWS - 1);

   logic [0:0]        state_q,      state_d;
   logic [CNT_W-1:0]  cnt_q,        cnt_d;
   logic [ROW_AW-1:0] row_addr_q,   row_addr_d;
   logic              row_en_q,     row_en_d;
   logic [COLS-1:0]   red_col_q,    red_col_d;
   logic [COLS-1:0]   green_col_q,  green_col_d;
   logic              frame_done_q, frame_done_d;
   row_t              rd_red;
   row_t              rd_green;

   // frame_done_q marks the final DRIVE cycle of the last row, which is
   // exactly the cycle whose closing edge must swap buffers.
   frame_double_buffer u_buf (
      .clock    (clock),
      .reset_n  (reset_n),
      .wr_red   (frame_red),
      .wr_green (frame_green),
      .wr_valid (frame_valid),
      .wr_ready (frame_ready),
      .swap     (frame_done_q),
      .rd_addr  (row_addr_q),
      .rd_red   (rd_red),
      .rd_green (rd_green)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CNT_W'(1);
      row_addr_d = row_addr_q;
      case (state_q)
         S_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = S_DRIVE;
               cnt_d   = '0;
            end
         end
         default: begin
            if (cnt_q == DWELL_LAST) begin
               state_d    = S_BLANK;
               cnt_d      = '0;
               row_addr_d = (row_addr_q == ROW_LAST) ? '0 : row_addr_q + ROW_AW'(1);
            end
         end
      endcase
      // Outputs are registered from the next state so they move only at
      // state boundaries. Row address is unchanged on BLANK->DRIVE, so the
      // read port already points at the row about to be driven.
      row_en_d     = (state_d == S_DRIVE);
      red_col_d    = row_en_d ? rd_red   : '0;
      green_col_d  = row_en_d ? rd_green : '0;
      frame_done_d = row_en_d && (cnt_d == DWELL_LAST) && (row_addr_d == ROW_LAST);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_BLANK;
         cnt_q        <= '0;
         row_addr_q   <= '0;
         row_en_q     <= 1'b0;
         red_col_q    <= '0;
         green_col_q  <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         row_addr_q   <= row_addr_d;
         row_en_q     <= row_en_d;
         red_col_q    <= red_col_d;
         green_col_q  <= green_col_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign row_addr   = row_addr_q;
   assign row_en     = row_en_q;
   assign red_col    = red_col_q;
   assign green_col  = green_col_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner with a short scan (dwell 4, blank 2).
// Latency: reference model advances once per clock alongside the DUT.
// Backpressure: producer holds valid and data until the handshake completes.
module tb_led_matrix_scanner;

   localparam int DW  = 4;
   localparam int BL  = 2;
   localparam int PER = DW + BL;
   localparam int FP  = 16 * PER;

   logic         clock = 1'b0;
   logic         reset_n;
   logic [255:0] frame_red, frame_green;
   logic         frame_valid;
   logic         frame_ready, frame_done, row_en;
   logic [3:0]   row_addr;
   logic [15:0]  red_col, green_col;

   int total = 0;
   int bad   = 0;

   // Reference model: position in the scan is pure arithmetic on k, the
   // number of clock edges since reset release; buffers are plain vectors.
   int           k;
   logic [255:0] m_ar, m_ag, m_sr, m_sg;
   logic         m_full;

   always #5 clock = ~clock;

   led_matrix_scanner #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .frame_red   (frame_red),
      .frame_green (frame_green),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .frame_done  (frame_done),
      .row_addr    (row_addr),
      .row_en      (row_en),
      .red_col     (red_col),
      .green_col   (green_col)
   );

   function automatic logic [38:0] dut_vec();
      return {row_en, row_addr, red_col, green_col, frame_done, frame_ready};
   endfunction

   function automatic logic [38:0] exp_vec();
      int row, ph;
      logic en;
      logic [15:0] r, g;
      logic [3:0] ra;
      row = (k / PER) % 16;
      ph  = k % PER;
      en  = (ph >= BL);
      r   = en ? m_ar[row*16 +: 16] : 16'h0;
      g   = en ? m_ag[row*16 +: 16] : 16'h0;
      ra  = 4'(row);
      return {en, ra, r, g, ((k % FP) == FP - 1), ~m_full};
   endfunction

   function automatic logic [255:0] rand_frame();
      logic [255:0] f;
      for (int i = 0; i < 8; i++) f[i*32 +: 32] = $urandom;
      return f;
   endfunction

   // Advance one clock: model follows the frame-swap and handshake rules.
   task automatic tick();
      logic         done_now, v;
      logic [255:0] r, g;
      done_now = ((k % FP) == FP - 1);
      v = frame_valid;
      r = frame_red;
      g = frame_green;
      @(posedge clock);
      if (done_now && m_full) begin
         m_ar   = m_sr;
         m_ag   = m_sg;
         m_full = 1'b0;
      end else if (v && !m_full) begin
         m_sr   = r;
         m_sg   = g;
         m_full = 1'b1;
      end
      k++;
      #1;
   endtask

   task automatic model_reset();
      k = 0; m_ar = '0; m_ag = '0; m_sr = '0; m_sg = '0; m_full = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; frame_valid = 1'b0; frame_red = '0; frame_green = '0;
      model_reset();
      #1;
      total++;
      if (dut_vec() !== 39'h1) begin
         bad++;
         $display("FAIL reset_state got=%h exp=%h", dut_vec(), 39'h1);
      end
      @(posedge clock); #1;
      reset_n = 1'b1;
      k = 0;
   endtask

   task automatic test_idle();
      int dones = 0;
      for (int i = 0; i < 2 * FP + 10; i++) begin
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL idle_scan k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
         end
         if (i < 2 * FP && frame_done === 1'b1) dones++;
         tick();
      end
      total++;
      if (dones != 2) begin
         bad++;
         $display("FAIL idle_done_count got=%0d exp=2", dones);
      end
   endtask

   task automatic test_single_frame();
      for (int i = 0; i < FP && (k % FP) != 30; i++) begin
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL single_align k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
         end
         tick();
      end
      frame_red = '0; frame_green = '0;
      frame_red[3*16 +: 16] = 16'hA5A5;
      frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
      total++;
      if (frame_ready !== 1'b0) begin
         bad++;
         $display("FAIL single_ready_drop got=%b exp=0", frame_ready);
      end
      for (int i = 0; i < 2 * FP; i++) begin
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL single_scan k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int  acc_k = -1;
      for (int i = 0; i < FP && (k % FP) != 10; i++) tick();
      frame_red = rand_frame(); frame_green = rand_frame(); frame_valid = 1'b1;
      tick();
      frame_red = rand_frame(); frame_green = rand_frame();
      for (int i = 0; i < 2 * FP; i++) begin
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL b2b_hold k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
         end
         if (frame_ready === 1'b1) acc_k = k;
         tick();
         if (acc_k >= 0) break;
      end
      frame_valid = 1'b0;
      total++;
      if (acc_k < 0 || (acc_k % FP) != 0) begin
         bad++;
         $display("FAIL b2b_accept_cycle got=%0d exp=phase0", (acc_k < 0) ? -1 : acc_k % FP);
      end
      for (int i = 0; i < 2 * FP; i++) begin
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL b2b_scan k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_swap_collision();
      for (int i = 0; i < FP && (k % FP) != 50; i++) tick();
      frame_red = rand_frame(); frame_green = rand_frame(); frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
      for (int i = 0; i < FP && (k % FP) != FP - 1; i++) tick();
      frame_red = rand_frame(); frame_green = rand_frame(); frame_valid = 1'b1;
      total++;
      if (frame_ready !== 1'b0 || frame_done !== 1'b1) begin
         bad++;
         $display("FAIL collide_swap_cycle got ready=%b done=%b exp ready=0 done=1",
                  frame_ready, frame_done);
      end
      tick();
      total++;
      if (frame_ready !== 1'b1) begin
         bad++;
         $display("FAIL collide_ready_rise got=%b exp=1", frame_ready);
      end
      tick();
      frame_valid = 1'b0;
      total++;
      if (frame_ready !== 1'b0) begin
         bad++;
         $display("FAIL collide_capture got ready=%b exp=0", frame_ready);
      end
      for (int i = 0; i < 2 * FP; i++) begin
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL collide_scan k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      frame_red = rand_frame(); frame_green = rand_frame(); frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
      for (int i = 0; i < FP && (k % FP) != 9 * PER + BL + 1; i++) tick();
      total++;
      if (row_en !== 1'b1 || row_addr !== 4'd9) begin
         bad++;
         $display("FAIL areset_pre got en=%b row=%0d exp en=1 row=9", row_en, row_addr);
      end
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if ({row_en, row_addr, red_col, green_col} !== 37'h0) begin
         bad++;
         $display("FAIL areset_async got=%h exp=0", {row_en, row_addr, red_col, green_col});
      end
      model_reset();
      @(posedge clock); #1;
      reset_n = 1'b1;
      k = 0;
      for (int i = 0; i < FP + 20; i++) begin
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL areset_after k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic prev_en;
      int   run = 0;
      bit   first = 1'b1;
      logic hs;
      prev_en = row_en;
      for (int i = 0; i < 8 * FP; i++) begin
         if (!frame_valid && ($urandom_range(0, 3) == 0)) begin
            frame_red = rand_frame(); frame_green = rand_frame(); frame_valid = 1'b1;
         end
         total++;
         if (dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL random_scan k=%0d got=%h exp=%h", k, dut_vec(), exp_vec());
         end
         if (row_en !== 1'b1 && (red_col !== 16'h0 || green_col !== 16'h0)) begin
            bad++;
            $display("FAIL random_dark_cols k=%0d red=%h green=%h exp=0", k, red_col, green_col);
         end
         if (row_en === prev_en) begin
            run++;
         end else begin
            if (!first) begin
               total++;
               if (run != (prev_en ? DW : BL)) begin
                  bad++;
                  $display("FAIL random_window en=%b got=%0d exp=%0d", prev_en, run,
                           prev_en ? DW : BL);
               end
            end
            first = 1'b0;
            run = 1;
            prev_en = row_en;
         end
         hs = frame_valid && frame_ready;
         tick();
         if (hs) frame_valid = 1'b0;
      end
      frame_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single_frame();
      test_back_to_back();
      test_swap_collision();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
